// File: rtl/td4_core_if.sv
// rtl/td4_core_if.sv - program-ROM bus between the TD4 core and its instruction ROM
interface td4_core_if;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;

   modport master (output rom_addr, input rom_data);
   modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/td4_core.sv
// rtl/td4_core.sv - TD4 4-bit CPU execution core with tick prescaler
// Optional self-loop halt detector enabled by TD4_HALT_DETECT_EN.
module td4_core #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        reset,
   td4_core_if.master  rom,
   input  logic [3:0]  in_port,
   output logic [3:0]  out_port,
   output logic        carry,
   output logic        halted
);
   localparam logic [23:0] DIV_LAST = 24'(CLK_DIV - 1);

   logic [23:0] presc_q, presc_d;
   logic [3:0]  pc_q, pc_d;
   logic [3:0]  a_q, a_d;
   logic [3:0]  b_q, b_d;
   logic [3:0]  out_q, out_d;
   logic        c_q, c_d;

   logic        tick;
   logic [3:0]  op;
   logic [3:0]  im;
   logic [3:0]  src;
   logic [4:0]  sum;

   assign tick = (presc_q == DIV_LAST);
   assign op   = rom.rom_data[7:4];
   assign im   = rom.rom_data[3:0];

   // Source operand of the shared adder; unnamed sources contribute zero.
   always_comb begin
      src = 4'd0;
      case (op)
         4'b0000, 4'b0100: src = a_q;
         4'b0101, 4'b0001, 4'b1001: src = b_q;
         4'b0010, 4'b0110: src = in_port;
         default: src = 4'd0;
      endcase
   end

   assign sum = {1'b0, src} + {1'b0, im};

   always_comb begin
      presc_d = tick ? 24'd0 : presc_q + 24'd1;
      pc_d    = pc_q;
      a_d     = a_q;
      b_d     = b_q;
      out_d   = out_q;
      c_d     = c_q;
      if (tick) begin
         pc_d = pc_q + 4'd1;
         c_d  = sum[4];
         case (op)
            4'b0000, 4'b0011, 4'b0001, 4'b0010: a_d = sum[3:0];
            4'b0101, 4'b0111, 4'b0100, 4'b0110: b_d = sum[3:0];
            4'b1001, 4'b1011: out_d = sum[3:0];
            4'b1111: pc_d = im;
            // JNC tests the carry left by the previous instruction.
            4'b1110: if (!c_q) pc_d = im;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= 24'd0;
         pc_q    <= 4'd0;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         out_q   <= 4'd0;
         c_q     <= 1'b0;
      end else begin
         presc_q <= presc_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         out_q   <= out_d;
         c_q     <= c_d;
      end
   end

   assign rom.rom_addr = pc_q;
   assign out_port     = out_q;
   assign carry        = c_q;

`ifdef TD4_HALT_DETECT_EN
   logic halted_q, halted_d, halt_hit;

   assign halt_hit = (im == pc_q) && ((op == 4'b1111) || ((op == 4'b1110) && !c_q));
   assign halted_d = halted_q | (tick & halt_hit);

   always_ff @(posedge clk) begin
      if (reset) halted_q <= 1'b0;
      else       halted_q <= halted_d;
   end

   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif
endmodule

// File: doc/td4_core.md
# td4_core

Sequential execution core of the TD4 4-bit CPU. It drives the 4-bit program-ROM address and executes one 8-bit ROM word per instruction tick. Each word is a 4-bit opcode plus a 4-bit immediate. The core holds the architectural state: PC, registers A and B, the carry flag C and the output latch. It also has a programmable tick prescaler so LED programs run at a visible rate.

## Interface
- `CLK_DIV`, default 1: system clocks per instruction; legal range 1..2^24.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one reset, reset synchronous active-high.
- `rom_addr`  out  4  program address, equal to the PC register.
- `rom_data`  in  8  instruction word from the combinational ROM; [7:4] is the opcode, [3:0] is Im.
- `in_port`  in  4  input switches, sampled only by IN instructions.
- `out_port`  out  4  output latch, driving the LEDs.
- `carry`  out  1  the C flag.
- `halted`  out  1  sticky self-loop indicator; see Configuration.

## Operation
- Reset values: PC=0, A=0, B=0, out_port=0, C=0, halted=0, prescaler=0.
- The prescaler counts 0..CLK_DIV-1 and wraps.
- An execute tick occurs in any cycle where the prescaler equals CLK_DIV-1. With CLK_DIV=1, every cycle is an execute tick.
- Architectural state changes only at an execute-tick edge.
- Every instruction computes a 5-bit sum = {0,src} + {0,Im}. The defined sources are listed below; the sum is 0+Im where no source is named.
  - sum[3:0] is the result.
  - C ← sum[4] on every executed instruction, including MOV, IN, OUT, jumps and NOP.
- Opcodes:
  - 0000 ADD A,Im: A←A+Im.
  - 0101 ADD B,Im: B←B+Im.
  - 0011 MOV A,Im: A←Im.
  - 0111 MOV B,Im: B←Im.
  - 0001 MOV A,B: A←B+Im.
  - 0100 MOV B,A: B←A+Im.
  - 0010 IN A: A←in_port+Im.
  - 0110 IN B: B←in_port+Im.
  - 1001 OUT B: out_port←B+Im.
  - 1011 OUT Im: out_port←Im.
  - 1111 JMP Im: PC←Im.
  - 1110 JNC Im: PC←Im if C==0 before this instruction, else PC+1.
  - 1000, 1010, 1100, 1101: NOP. PC+1, C←0, no other change.
- PC increments modulo 16; 1111 wraps to 0000. Jumps replace the increment.
- The JNC decision uses C as it stood before the JNC. The JNC itself then writes C←0.

## Timing
- rom_addr is registered and equals PC. rom_data is consumed in the same cycle (zero-latency ROM).
- Instruction latency: one execute tick. The effect is visible on outputs the cycle after the tick edge.
- Instruction throughput: one instruction per CLK_DIV clocks.
- Between ticks, all outputs hold. Changes on rom_data or in_port between ticks have no effect.
- Reset has priority over an execute tick in the same cycle.
- Reset mid-program: all state returns to reset values at that edge. The first tick after release executes address 0, after a full CLK_DIV count.

## Configuration
- Macro: `TD4_HALT_DETECT_EN`.
- Defined: `halted` is set at an execute tick whose instruction is either:
  - JMP with Im==PC, or
  - JNC with Im==PC and C==0.
- The `halted` flag is sticky until reset. Execution continues regardless; the program simply loops.
- Undefined: `halted` is constant 0 and the comparator logic is absent.

## Test plan
- LED program, CLK_DIV=1.
  - Stimulus: ROM = 10110011, 10110110, 10111100, 10111000, 10111000, 10111100, 10110110, 10110011, 10110001, 11110000.
  - Required: out_port steps 0011→0110→1100→1000→1000→1100→0110→0011→0001, one value per clock. rom_addr returns to 0 after the 10th tick and the pattern repeats.
- Carry and JNC.
  - Stimulus: MOV A,1111; ADD A,0001; JNC 0000; OUT 0101.
  - Required: A=0000 and C=1 after the ADD. The JNC falls through and clears C. out_port=0101 at PC=3.
- Taken jump.
  - Stimulus: ADD A,0001 from A=0; JNC 1000.
  - Required: PC=1000 after the JNC tick.
- Prescaler, CLK_DIV=4.
  - Required: rom_addr changes only every 4th clock. The first change comes 4 clocks after reset release.
- IN and OUT B.
  - Stimulus: in_port=1010; IN B,0000; OUT B,0001.
  - Required: B=1010, C=0, out_port=1011.
- Reset mid-run and halt.
  - Stimulus: assert reset during the LED program; separately run MOV A,0; JMP 0001.
  - Required on reset: all outputs return to reset values the next cycle. For the JMP self-loop with the macro defined: halted=1 one cycle after the first JMP tick, and it clears only on reset.
